// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared widths and FSM state codes for the data-memory responder
package dmem_responder_pkg;

    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DEPTH  = 2 ** DMEM_ADDR_W;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with synchronous write and combinational read, no reset
module dmem_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with programmable access latency
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LAT    = 4,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_rdata
);

    localparam int CNT_W = $clog2(LAT + 1);

    dm_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              resp_we_q, resp_we_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              access;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] arr_rdata;

    // With LAT=1 the array is accessed on the fire edge itself, straight from the request bus.
    assign access    = (LAT == 1) ? (state_q == DM_IDLE && req_valid)
                                  : (state_q == DM_WAIT && cnt_q == '0);
    assign acc_we    = (LAT == 1) ? req_we    : we_q;
    assign acc_addr  = (LAT == 1) ? req_addr  : addr_q;
    assign acc_wdata = (LAT == 1) ? req_wdata : wdata_q;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .we_i    (access && acc_we),
        .waddr_i (acc_addr),
        .wdata_i (acc_wdata),
        .raddr_i (acc_addr),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        resp_we_d    = resp_we_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            DM_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = (LAT == 1) ? DM_RESP : DM_WAIT;
                end
            end
            DM_WAIT: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DM_RESP;
                end
            end
            DM_RESP: begin
                if (resp_ready) begin
                    state_d = DM_IDLE;
                end
            end
            default: state_d = DM_IDLE;
        endcase
        if (access) begin
            resp_we_d    = acc_we;
            resp_rdata_d = acc_we ? '0 : arr_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DM_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            resp_we_q    <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            resp_we_q    <= resp_we_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == DM_IDLE);
    assign resp_valid = (state_q == DM_RESP);
    assign resp_we    = resp_we_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LAT=4 and LAT=1
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v4, rdy4, we4, rv4, rr4, rwe4;
    logic [6:0]  addr4;
    logic [31:0] wd4, rd4;

    logic        v1, rdy1, we1, rv1, rr1, rwe1;
    logic [6:0]  addr1;
    logic [31:0] wd1, rd1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LAT(4), .ADDR_W(7), .DATA_W(32)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (v4),
        .req_ready  (rdy4),
        .req_we     (we4),
        .req_addr   (addr4),
        .req_wdata  (wd4),
        .resp_valid (rv4),
        .resp_ready (rr4),
        .resp_we    (rwe4),
        .resp_rdata (rd4)
    );

    dmem_responder #(.LAT(1), .ADDR_W(7), .DATA_W(32)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (v1),
        .req_ready  (rdy1),
        .req_we     (we1),
        .req_addr   (addr1),
        .req_wdata  (wd1),
        .resp_valid (rv1),
        .resp_ready (rr1),
        .resp_we    (rwe1),
        .resp_rdata (rd1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issues one request on the LAT=4 instance; lat counts clock edges from fire to resp_valid.
    task automatic do_req4(input logic we, input logic [6:0] a, input logic [31:0] d,
                           output int lat, output logic rwe, output logic [31:0] rd);
        @(negedge clk);
        v4 = 1'b1; we4 = we; addr4 = a; wd4 = d; rr4 = 1'b1;
        check_eq("req_ready_idle", {31'd0, rdy4}, 32'd1);
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            v4 = 1'b0;
            if (rv4) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check_eq("resp_timeout", 32'd0, 32'd1);
        rwe = rwe4;
        rd  = rd4;
    endtask

    int          lat;
    logic        rwe;
    logic [31:0] rd;

    logic        op_we [40];
    logic [6:0]  op_a  [40];
    logic [31:0] op_d  [40];
    logic [31:0] mdl   [128];

    initial begin
        int          cyc, last_fire, exp_cyc, op_i, n_resp, j;
        logic        exp_we;
        logic [31:0] exp_rd;

        rst_n = 1'b0;
        v4 = 0; we4 = 0; addr4 = 0; wd4 = 0; rr4 = 1;
        v1 = 0; we1 = 0; addr1 = 0; wd1 = 0; rr1 = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready4",  {31'd0, rdy4}, 32'd1);
        check_eq("rst_resp_valid4", {31'd0, rv4},  32'd0);
        check_eq("rst_resp_we4",    {31'd0, rwe4}, 32'd0);
        check_eq("rst_resp_rdata4", rd4,           32'd0);
        check_eq("rst_req_ready1",  {31'd0, rdy1}, 32'd1);
        check_eq("rst_resp_valid1", {31'd0, rv1},  32'd0);

        // Store then load at address 5
        do_req4(1'b1, 7'd5, 32'hDEADBEEF, lat, rwe, rd);
        check_eq("st5_latency", lat, 32'd4);
        check_eq("st5_resp_we", {31'd0, rwe}, 32'd1);
        check_eq("st5_rdata",   rd, 32'd0);
        do_req4(1'b0, 7'd5, 32'h0, lat, rwe, rd);
        check_eq("ld5_latency", lat, 32'd4);
        check_eq("ld5_resp_we", {31'd0, rwe}, 32'd0);
        check_eq("ld5_rdata",   rd, 32'hDEADBEEF);

        // Top and bottom of the array
        do_req4(1'b1, 7'd127, 32'h1, lat, rwe, rd);
        do_req4(1'b1, 7'd0,   32'h2, lat, rwe, rd);
        do_req4(1'b0, 7'd127, 32'h0, lat, rwe, rd);
        check_eq("ld127_rdata", rd, 32'h1);
        do_req4(1'b0, 7'd0, 32'h0, lat, rwe, rd);
        check_eq("ld0_rdata", rd, 32'h2);

        // Back-pressure on a load response
        @(negedge clk);
        v4 = 1'b1; we4 = 1'b0; addr4 = 7'd5; rr4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        for (int k = 0; k < 20 && !rv4; k++) @(negedge clk);
        check_eq("bp_resp_seen", {31'd0, rv4}, 32'd1);
        v4 = 1'b1; we4 = 1'b1; addr4 = 7'd20; wd4 = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_resp_valid", {31'd0, rv4},  32'd1);
            check_eq("bp_resp_rdata", rd4,           32'hDEADBEEF);
            check_eq("bp_req_ready",  {31'd0, rdy4}, 32'd0);
            @(negedge clk);
        end
        rr4 = 1'b1;
        @(negedge clk);
        check_eq("bp_ready_after_hs", {31'd0, rdy4}, 32'd1);
        @(negedge clk);
        check_eq("bp_next_fired", {31'd0, rdy4}, 32'd0);
        v4 = 1'b0;
        for (int k = 0; k < 20 && !rv4; k++) @(negedge clk);
        check_eq("bp_store_resp_we", {31'd0, rwe4}, 32'd1);
        check_eq("bp_store_rdata",   rd4, 32'd0);
        @(negedge clk);

        // Asynchronous reset between edges while a load is in flight
        do_req4(1'b0, 7'd5, 32'h0, lat, rwe, rd);
        @(negedge clk);
        v4 = 1'b1; we4 = 1'b0; addr4 = 7'd20;
        @(negedge clk);
        v4 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_req_ready",  {31'd0, rdy4}, 32'd1);
        check_eq("async_resp_valid", {31'd0, rv4},  32'd0);
        check_eq("async_resp_we",    {31'd0, rwe4}, 32'd0);
        check_eq("async_resp_rdata", rd4,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset two cycles after firing a store: the store must be dropped
        do_req4(1'b1, 7'd9, 32'h11112222, lat, rwe, rd);
        @(negedge clk);
        v4 = 1'b1; we4 = 1'b1; addr4 = 7'd9; wd4 = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq("drop_no_resp", {31'd0, rv4}, 32'd0);
            @(negedge clk);
        end
        do_req4(1'b0, 7'd9, 32'h0, lat, rwe, rd);
        check_eq("drop_ld9_rdata", rd, 32'h11112222);

        // LAT=1 streaming against a reference model
        for (int i = 0; i < 20; i++) begin
            op_we[2*i]   = 1'b1;
            op_a[2*i]    = 7'($urandom_range(0, 127));
            op_d[2*i]    = $urandom;
            j            = $urandom_range(0, i);
            op_we[2*i+1] = 1'b0;
            op_a[2*i+1]  = op_a[2*j];
            op_d[2*i+1]  = 32'h0;
        end
        cyc = 0; last_fire = 0; exp_cyc = 0; op_i = 0; n_resp = 0;
        exp_we = 1'b0; exp_rd = 32'h0;
        @(negedge clk);
        v1 = 1'b1; we1 = op_we[0]; addr1 = op_a[0]; wd1 = op_d[0]; rr1 = 1'b1;
        for (int it = 0; it < 200; it++) begin
            if (rv1) begin
                check_eq("l1_resp_latency", cyc, exp_cyc);
                check_eq("l1_resp_we", {31'd0, rwe1}, {31'd0, exp_we});
                check_eq("l1_resp_rdata", rd1, exp_rd);
                n_resp++;
            end
            if (rdy1 && v1) begin
                if (op_i > 0) check_eq("l1_fire_spacing", cyc - last_fire, 32'd2);
                last_fire = cyc;
                exp_cyc   = cyc + 1;
                exp_we    = op_we[op_i];
                if (op_we[op_i]) begin
                    mdl[op_a[op_i]] = op_d[op_i];
                    exp_rd = 32'h0;
                end else begin
                    exp_rd = mdl[op_a[op_i]];
                end
                op_i++;
            end else if (!rdy1) begin
                if (op_i < 40) begin
                    we1 = op_we[op_i]; addr1 = op_a[op_i]; wd1 = op_d[op_i];
                end else begin
                    v1 = 1'b0;
                end
            end
            if (n_resp == 40) break;
            @(negedge clk);
            cyc++;
        end
        v1 = 1'b0;
        check_eq("l1_resp_count", n_resp, 32'd40);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
